// File: rtl/z80_mem_arbiter_pkg.sv
// Shared types and constants for the Z80 / download-loader memory arbiter.
package z80_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_CPU_WR,
    ST_DL_WRITE,
    ST_DONE
  } arb_state_e;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // Inclusive window test; the offset form avoids a constant compare when lo is zero.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    logic [15:0] off;
    logic [15:0] span;
    off  = addr - lo;
    span = hi - lo;
    return off <= span;
  endfunction

endpackage

// File: rtl/z80_mem_arbiter_timeout_cnt.sv
// Saturating 8-bit transaction watchdog: cleared while idle, counts busy cycles.
module z80_mem_arbiter_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Counter holds completed wait cycles, so expiry fires on the LIMIT-th busy cycle.
  localparam logic [7:0] TERM = 8'(LIMIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q >= TERM);

endmodule

// File: rtl/z80_mem_arbiter.sv
// Shares one req/ack memory port between Z80 MREQ cycles and the download loader,
// stretching CPU cycles with nWAIT, write-protecting ROM and bounding each access.
//
//   state       | meaning
//   ST_IDLE     | no memory cycle; pick loader write, CPU read or CPU write
//   ST_CPU_RD   | CPU read in flight, MEM_REQ held until ack/timeout
//   ST_CPU_WR   | CPU write in flight, MEM_REQ held until ack/timeout
//   ST_DL_WRITE | loader write in flight, MEM_REQ held until ack/timeout
//   ST_DONE     | one-cycle MEM_REQ low gap before the next transaction
module z80_mem_arbiter
  import z80_mem_arbiter_pkg::*;
#(
  parameter int          MEM_AW  = 18,
  parameter logic [15:0] WP_LO   = 16'h0000,
  parameter logic [15:0] WP_HI   = 16'h3FFF,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mreq_n_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  input  logic [15:0]       sda_i,
  input  logic [7:0]        sdd_out_i,
  output logic [7:0]        sdd_in_o,
  output logic              wait_n_o,
  input  logic              dl_active_i,
  input  logic              dl_wr_i,
  input  logic [MEM_AW-1:0] dl_addr_i,
  input  logic [7:0]        dl_data_i,
  output logic              dl_busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_din_o,
  input  logic [7:0]        mem_dout_i,
  input  logic              mem_ack_i,
  output logic              timeout_err_o
);

  arb_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [7:0]        sdd_q, sdd_d;
  logic              err_q, err_d;
  logic              served_q, served_d;
  logic              dl_pend_q, dl_pend_d;
  logic [MEM_AW-1:0] dl_addr_q, dl_addr_d;
  logic [7:0]        dl_data_q, dl_data_d;

  logic cpu_acc;
  logic dl_wr_ok;
  logic busy;
  logic tmo_expired;
  logic xfer_end;

  assign cpu_acc  = ~mreq_n_i & (~rd_n_i | ~wr_n_i);
  // A strobe arriving while a write is already pending is a loader protocol error.
  assign dl_wr_ok = dl_wr_i & dl_active_i & ~dl_pend_q;
  assign busy     = (state_q == ST_CPU_RD) || (state_q == ST_CPU_WR) ||
                    (state_q == ST_DL_WRITE);
  assign xfer_end = busy & (mem_ack_i | tmo_expired);

  z80_mem_arbiter_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (~busy),
    .en_i      (busy),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    sdd_d     = sdd_q;
    err_d     = err_q;
    served_d  = served_q;
    dl_pend_d = dl_pend_q;
    dl_addr_d = dl_addr_q;
    dl_data_d = dl_data_q;

    if (!cpu_acc) begin
      served_d = 1'b0;
    end

    if (dl_wr_ok) begin
      dl_pend_d = 1'b1;
      dl_addr_d = dl_addr_i;
      dl_data_d = dl_data_i;
    end

    case (state_q)
      ST_IDLE: begin
        // A same-cycle loader strobe is taken straight from the inputs so it beats the CPU.
        if (dl_pend_q || dl_wr_ok) begin
          state_d = ST_DL_WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = dl_pend_q ? dl_addr_q : dl_addr_i;
          din_d   = dl_pend_q ? dl_data_q : dl_data_i;
        end else if (cpu_acc && !served_q) begin
          if (!rd_n_i) begin
            state_d = ST_CPU_RD;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = MEM_AW'(sda_i);
          end else if (in_window(sda_i, WP_LO, WP_HI)) begin
            served_d = 1'b1;
          end else begin
            state_d = ST_CPU_WR;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = MEM_AW'(sda_i);
            din_d   = sdd_out_i;
          end
        end
      end

      ST_CPU_RD, ST_CPU_WR, ST_DL_WRITE: begin
        if (xfer_end) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!mem_ack_i) begin
            err_d = 1'b1;
          end
          if (state_q == ST_DL_WRITE) begin
            dl_pend_d = 1'b0;
          end else begin
            // Strobe already gone: the CPU abandoned the cycle, so nothing is delivered.
            served_d = cpu_acc;
            if ((state_q == ST_CPU_RD) && cpu_acc) begin
              sdd_d = mem_ack_i ? mem_dout_i : OPEN_BUS;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= 8'h00;
      sdd_q     <= OPEN_BUS;
      err_q     <= 1'b0;
      served_q  <= 1'b0;
      dl_pend_q <= 1'b0;
      dl_addr_q <= '0;
      dl_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      sdd_q     <= sdd_d;
      err_q     <= err_d;
      served_q  <= served_d;
      dl_pend_q <= dl_pend_d;
      dl_addr_q <= dl_addr_d;
      dl_data_q <= dl_data_d;
    end
  end

  assign wait_n_o      = ~(cpu_acc & ~served_q);
  assign sdd_in_o      = sdd_q;
  assign dl_busy_o     = dl_pend_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_din_o     = din_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Scoreboard bench for z80_mem_arbiter: directed CPU/loader traffic against a req/ack memory model.
module tb_z80_mem_arbiter;

  localparam int AW = 18;
  localparam int TMO = 255;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    int            len;
  } mem_exp_t;

  typedef struct {
    logic       is_rd;
    logic [7:0] data;
    int         wcnt;
  } cpu_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0]   sda = 16'h0000;
  logic [7:0]    sdd_out = 8'h00;
  logic [7:0]    sdd_in;
  logic          wait_n;
  logic          dl_active = 1'b0, dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = 8'h00;
  logic          dl_busy;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = 8'h00;
  logic          mem_ack = 1'b0;
  logic          timeout_err;

  int n_checks = 0;
  int n_pass = 0;
  int ack_delay = 3;
  logic [7:0] mem [logic [AW-1:0]];

  mem_exp_t exp_mem[$];
  cpu_exp_t exp_cpu[$];

  always #5 clk = ~clk;

  z80_mem_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mreq_n_i      (mreq_n),
    .rd_n_i        (rd_n),
    .wr_n_i        (wr_n),
    .sda_i         (sda),
    .sdd_out_i     (sdd_out),
    .sdd_in_o      (sdd_in),
    .wait_n_o      (wait_n),
    .dl_active_i   (dl_active),
    .dl_wr_i       (dl_wr),
    .dl_addr_i     (dl_addr),
    .dl_data_i     (dl_data),
    .dl_busy_o     (dl_busy),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_din_o     (mem_din),
    .mem_dout_i    (mem_dout),
    .mem_ack_i     (mem_ack),
    .timeout_err_o (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void push_mem(input logic we, input logic [AW-1:0] a,
                                   input logic [7:0] d, input int len);
    mem_exp_t e;
    e.we = we; e.addr = a; e.din = d; e.len = len;
    exp_mem.push_back(e);
  endfunction

  function automatic void push_cpu(input logic is_rd, input logic [7:0] d, input int wcnt);
    cpu_exp_t e;
    e.is_rd = is_rd; e.data = d; e.wcnt = wcnt;
    exp_cpu.push_back(e);
  endfunction

  // Memory model: acks in the ack_delay-th cycle of MEM_REQ; ack_delay=0 never acks.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack  = 1'b0;
      mem_dout = 8'h00;
      if (mem_req) begin
        rcnt++;
        if (ack_delay != 0 && rcnt == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_din;
          else mem_dout = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Memory-side monitor: one expected entry per MEM_REQ rise, length checked at the fall.
  initial begin
    logic     prev;
    int       len;
    mem_exp_t cur;
    prev = 1'b0;
    len = 0;
    cur.len = -1;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        len = 1;
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", 32'd1, 32'd0);
          cur.len = -1;
        end else begin
          cur = exp_mem.pop_front();
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
          if (cur.we) chk("mem_din", 32'(mem_din), 32'(cur.din));
        end
      end else if (mem_req) begin
        len++;
      end else if (prev && cur.len >= 0) begin
        chk("mem_req_len", 32'(len), 32'(cur.len));
      end
      prev = mem_req;
    end
  end

  // CPU-side monitor: one completion per strobe assertion, counted by nWAIT-low cycles.
  initial begin
    int       wcnt;
    bit       done;
    bit       retrig;
    cpu_exp_t e;
    wcnt = 0; done = 0; retrig = 0;
    forever begin
      @(negedge clk);
      if (!(!mreq_n && (!rd_n || !wr_n))) begin
        if (done) chk("held_strobe_rewait", 32'(retrig), 32'd0);
        wcnt = 0; done = 0; retrig = 0;
      end else if (!done) begin
        if (!wait_n) wcnt++;
        else begin
          done = 1;
          if (exp_cpu.size() == 0) chk("cpu_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_cpu.pop_front();
            chk("wait_cycles", 32'(wcnt), 32'(e.wcnt));
            if (e.is_rd) chk("rd_data", 32'(sdd_in), 32'(e.data));
          end
        end
      end else if (!wait_n) begin
        retrig = 1;
      end
    end
  end

  task automatic cpu_op(input logic is_rd, input logic [15:0] a, input logic [7:0] d,
                        input int hold);
    int t;
    @(posedge clk); #1;
    sda = a; sdd_out = d; mreq_n = 1'b0;
    if (is_rd) rd_n = 1'b0; else wr_n = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wait_n && t < 600);
    if (!wait_n) chk("cpu_wait_bound", 32'd0, 32'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sdd_in"}, 32'(sdd_in), 32'hFF);
    chk({tag, "_wait_n"}, 32'(wait_n), 32'd1);
    chk({tag, "_dl_busy"}, 32'(dl_busy), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int busy_cyc;
    mem[18'h07123] = 8'h5A;
    mem[18'h01234] = 8'hC3;
    mem[18'h01235] = 8'h3C;
    mem[18'h00010] = 8'h11;

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted while a CPU read is in flight.
    push_mem(1'b0, 18'h00200, 8'h00, -1);
    @(posedge clk); #1;
    sda = 16'h0200; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_req_up", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b1;
    #1 chk_reset_vals("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    push_mem(1'b0, 18'h07123, 8'h00, 3);
    push_cpu(1'b1, 8'h5A, 4);
    cpu_op(1'b1, 16'h7123, 8'h00, 0);

    push_cpu(1'b0, 8'h00, 1);
    cpu_op(1'b0, 16'h0010, 8'hAA, 0);
    chk("wp_not_written", 32'(mem[18'h00010]), 32'h11);

    push_mem(1'b1, 18'h07000, 8'hAA, 3);
    push_cpu(1'b0, 8'h00, 4);
    cpu_op(1'b0, 16'h7000, 8'hAA, 0);

    push_mem(1'b0, 18'h07000, 8'h00, 3);
    push_cpu(1'b1, 8'hAA, 4);
    cpu_op(1'b1, 16'h7000, 8'h00, 0);

    push_mem(1'b0, 18'h00010, 8'h00, 3);
    push_cpu(1'b1, 8'h11, 4);
    cpu_op(1'b1, 16'h0010, 8'h00, 0);

    // Loader strobe in the same cycle as a CPU read: loader first, then the read.
    push_mem(1'b1, 18'h2C000, 8'h77, 3);
    push_mem(1'b0, 18'h07123, 8'h00, 3);
    push_cpu(1'b1, 8'h5A, 9);
    dl_active = 1'b1;
    @(posedge clk); #1;
    dl_wr = 1'b1; dl_addr = 18'h2C000; dl_data = 8'h77;
    sda = 16'h7123; mreq_n = 1'b0; rd_n = 1'b0;
    fork
      begin @(posedge clk); #1 dl_wr = 1'b0; end
    join_none
    t = 0; busy_cyc = 0;
    do begin
      @(negedge clk);
      t++;
      if (dl_busy) busy_cyc++;
    end while (!wait_n && t < 100);
    chk("dl_busy_cycles", 32'(busy_cyc), 32'd3);
    chk("dl_mem_written", 32'(mem.exists(18'h2C000) ? mem[18'h2C000] : 8'h00), 32'h77);
    @(posedge clk); #1;
    mreq_n = 1'b1; rd_n = 1'b1; dl_active = 1'b0;
    @(posedge clk);

    // Unacknowledged read times out and the error flag sticks.
    ack_delay = 0;
    push_mem(1'b0, 18'h05555, 8'h00, TMO);
    push_cpu(1'b1, 8'hFF, TMO + 1);
    cpu_op(1'b1, 16'h5555, 8'h00, 0);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    ack_delay = 3;

    push_mem(1'b0, 18'h07123, 8'h00, 3);
    push_cpu(1'b1, 8'h5A, 4);
    cpu_op(1'b1, 16'h7123, 8'h00, 0);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Strobe held long after completion must not start another cycle.
    push_mem(1'b0, 18'h01234, 8'h00, 3);
    push_cpu(1'b1, 8'hC3, 4);
    cpu_op(1'b1, 16'h1234, 8'h00, 8);
    push_mem(1'b0, 18'h01235, 8'h00, 3);
    push_cpu(1'b1, 8'h3C, 4);
    cpu_op(1'b1, 16'h1235, 8'h00, 8);

    repeat (10) @(negedge clk);
    chk("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    chk("exp_cpu_left", 32'(exp_cpu.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
